// File: rtl/ddr2_traffic_pkg.sv
// Shared state encoding, default parameters and helpers for the DDR2 local-side
// traffic master.
package ddr2_traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_DRAIN,
    ST_DONE
  } state_t;

  localparam int DEF_ADDR_W          = 24;
  localparam int DEF_DATA_W          = 32;
  localparam int DEF_BE_W            = 4;
  localparam int DEF_BURST           = 2;
  localparam int DEF_MAX_OUTSTANDING = 8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ddr2_traffic_checker.sv
// Read-return checker: regenerates the expected pattern beat by beat, counts
// miscompares and remembers the burst address of the first one.
module ddr2_traffic_checker
  import ddr2_traffic_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BURST  = DEF_BURST
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [DATA_W-1:0] i_seed,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_burst_ret,
  output logic              o_mismatch,
  output logic [15:0]       o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  logic [DATA_W-1:0] r_exp;
  logic [2:0]        r_beat;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_err_count;
  logic [ADDR_W-1:0] r_first_err_addr;
  logic              w_beat;

  assign w_beat           = i_enable && i_valid;
  assign o_mismatch       = w_beat && (i_rdata != r_exp);
  assign o_burst_ret      = w_beat && (r_beat == 3'(BURST - 1));
  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exp            <= '0;
      r_beat           <= '0;
      r_addr           <= '0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else if (i_clear) begin
      r_exp            <= i_seed;
      r_beat           <= '0;
      r_addr           <= i_base;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else if (w_beat) begin
      r_exp <= r_exp + DATA_W'(1);
      if (o_burst_ret) begin
        r_beat <= '0;
        r_addr <= r_addr + ADDR_W'(BURST);
      end else begin
        r_beat <= r_beat + 3'd1;
      end
      // err_count saturates, so "still zero" reliably marks the first miscompare
      if (o_mismatch) begin
        r_err_count <= sat_inc16(r_err_count);
        if (r_err_count == 16'd0) r_first_err_addr <= r_addr;
      end
    end
  end

endmodule

// File: rtl/ddr2_local_traffic_master.sv
// Write-then-readback traffic generator for a DDR2 controller local interface:
// writes cfg_num_bursts bursts of an incrementing pattern, reads them back, checks.
module ddr2_local_traffic_master
  import ddr2_traffic_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int BE_W            = DEF_BE_W,
  parameter int BURST           = DEF_BURST,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic              phy_clk,
  input  logic              reset_phy_clk_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [15:0]       cfg_num_bursts,
  input  logic [DATA_W-1:0] cfg_seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  input  logic              local_init_done,
  input  logic              local_ready,
  output logic [ADDR_W-1:0] local_address,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic              local_burstbegin,
  output logic [2:0]        local_size,
  output logic [BE_W-1:0]   local_be,
  output logic [DATA_W-1:0] local_wdata,
  input  logic [DATA_W-1:0] local_rdata,
  input  logic              local_rdata_valid
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_rst_sync;
  logic [15:0]       r_num_bursts;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [15:0]       r_wr_burst;
  logic [2:0]        r_wr_beat;
  logic [15:0]       r_rd_burst;
  logic [OUT_W-1:0]  r_outstanding;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic              w_start_ok;
  logic              w_wr_req;
  logic              w_rd_req;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_last_wr;
  logic              w_last_rd;
  logic              w_can_issue;
  logic              w_chk_en;
  logic              w_burst_ret;
  logic              w_mismatch;
  logic              w_final_ret;
  logic [15:0]       w_err_count;

  // Start is only honoured once the deassertion edge has crossed two flops
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) r_rst_sync <= 2'b00;
    else                  r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_start_ok  = start && local_init_done && r_rst_sync[1] &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_can_issue = r_outstanding < OUT_W'(MAX_OUTSTANDING);
  assign w_wr_req    = (r_state == ST_WR) && local_init_done;
  assign w_rd_req    = (r_state == ST_RD_ISSUE) && local_init_done && w_can_issue;
  assign w_wr_acc    = w_wr_req && local_ready;
  assign w_rd_acc    = w_rd_req && local_ready;
  assign w_last_wr   = (r_wr_beat == 3'(BURST - 1)) && (r_wr_burst == r_num_bursts - 16'd1);
  assign w_last_rd   = (r_rd_burst == r_num_bursts - 16'd1);
  assign w_chk_en    = local_init_done &&
                       ((r_state == ST_RD_ISSUE) || (r_state == ST_RD_DRAIN));
  assign w_final_ret = (r_state == ST_RD_DRAIN) && w_burst_ret &&
                       (r_outstanding == OUT_W'(1));

  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) r_state <= ST_IDLE;
    else                  r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    local_write_req  = w_wr_req;
    local_read_req   = w_rd_req;
    local_burstbegin = 1'b0;
    local_size       = 3'd0;
    local_be         = '0;
    local_wdata      = '0;
    local_address    = '0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_ok) w_state_next = (cfg_num_bursts == 16'd0) ? ST_DONE : ST_WR;
      end
      ST_WR: begin
        local_address    = r_wr_addr;
        local_wdata      = r_wr_data;
        local_be         = '1;
        local_size       = 3'(BURST);
        local_burstbegin = w_wr_req && (r_wr_beat == 3'd0);
        if (w_wr_acc && w_last_wr) w_state_next = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: begin
        local_address = r_rd_addr;
        if (w_rd_req) begin
          local_burstbegin = 1'b1;
          local_size       = 3'(BURST);
        end
        if (w_rd_acc && w_last_rd) w_state_next = ST_RD_DRAIN;
      end
      ST_RD_DRAIN: begin
        if (w_final_ret) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      r_num_bursts  <= '0;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_wr_data     <= '0;
      r_wr_burst    <= '0;
      r_wr_beat     <= '0;
      r_rd_burst    <= '0;
      r_outstanding <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
    end else if (w_start_ok) begin
      r_num_bursts  <= cfg_num_bursts;
      r_wr_addr     <= cfg_base_addr;
      r_rd_addr     <= cfg_base_addr;
      r_wr_data     <= cfg_seed;
      r_wr_burst    <= '0;
      r_wr_beat     <= '0;
      r_rd_burst    <= '0;
      r_outstanding <= '0;
      r_busy        <= (cfg_num_bursts != 16'd0);
      r_done        <= (cfg_num_bursts == 16'd0);
      r_pass        <= (cfg_num_bursts == 16'd0);
    end else begin
      if (w_wr_acc) begin
        r_wr_data <= r_wr_data + DATA_W'(1);
        if (r_wr_beat == 3'(BURST - 1)) begin
          r_wr_beat  <= '0;
          r_wr_burst <= r_wr_burst + 16'd1;
          r_wr_addr  <= r_wr_addr + ADDR_W'(BURST);
        end else begin
          r_wr_beat <= r_wr_beat + 3'd1;
        end
      end
      if (w_rd_acc) begin
        r_rd_burst <= r_rd_burst + 16'd1;
        r_rd_addr  <= r_rd_addr + ADDR_W'(BURST);
      end
      if (w_rd_acc && !w_burst_ret)      r_outstanding <= r_outstanding + OUT_W'(1);
      else if (!w_rd_acc && w_burst_ret) r_outstanding <= r_outstanding - OUT_W'(1);
      // Final beat's compare result is folded in directly, it lands in err_count this same edge
      if (w_final_ret) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= (w_err_count == 16'd0) && !w_mismatch;
      end
    end
  end

  ddr2_traffic_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BURST  (BURST)
  ) u_checker (
    .i_clk            (phy_clk),
    .i_rst_n          (reset_phy_clk_n),
    .i_clear          (w_start_ok),
    .i_base           (cfg_base_addr),
    .i_seed           (cfg_seed),
    .i_enable         (w_chk_en),
    .i_valid          (local_rdata_valid),
    .i_rdata          (local_rdata),
    .o_burst_ret      (w_burst_ret),
    .o_mismatch       (w_mismatch),
    .o_err_count      (w_err_count),
    .o_first_err_addr (first_err_addr)
  );

  assign err_count = w_err_count;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;

endmodule

// File: tb/tb_ddr2_local_traffic_master.sv
// Directed bench for ddr2_local_traffic_master with a behavioural memory and
// variable-latency read-return model.
module tb_ddr2_local_traffic_master;

  localparam int BURST = 2;
  localparam int MAXO  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] cfg_base;
  logic [15:0] cfg_num;
  logic [31:0] cfg_seed;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;
  logic        init_done;
  logic        ready;
  logic [23:0] address;
  logic        write_req, read_req, burstbegin;
  logic [2:0]  size;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;

  always #5 clk = ~clk;

  ddr2_local_traffic_master dut (
    .phy_clk           (clk),
    .reset_phy_clk_n   (rst_n),
    .start             (start),
    .cfg_base_addr     (cfg_base),
    .cfg_num_bursts    (cfg_num),
    .cfg_seed          (cfg_seed),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .err_count         (err_count),
    .first_err_addr    (first_err_addr),
    .local_init_done   (init_done),
    .local_ready       (ready),
    .local_address     (address),
    .local_write_req   (write_req),
    .local_read_req    (read_req),
    .local_burstbegin  (burstbegin),
    .local_size        (size),
    .local_be          (be),
    .local_wdata       (wdata),
    .local_rdata       (rdata),
    .local_rdata_valid (rdata_valid)
  );

  // Controls owned by the test sequence
  int rd_lat;
  int corrupt_idx;
  bit ready_toggle;
  bit arm_clear;

  // State owned by the memory/monitor process
  typedef struct { int due; logic [31:0] data; } beat_t;
  beat_t       pend[$];
  logic [31:0] mem[logic [23:0]];
  logic [31:0] wr_data_q[$];
  logic [23:0] wr_bb_q[$];
  logic [23:0] rd_addr_q[$];
  int cyc, last_due, out_cnt, ret_k, wr_k, ret_idx, max_out;
  int addr_hold_viol, stab_viol, both_viol, drop_viol, stall_cnt;
  bit hold_pending;
  logic [64:0] hold_vec;
  logic [23:0] wr_burst_addr;

  int vectors = 0;
  int miscompares = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        pend.delete();
        out_cnt = 0; ret_k = 0; wr_k = 0; hold_pending = 0; last_due = 0;
      end else begin
        if (start && arm_clear) begin
          wr_data_q.delete(); wr_bb_q.delete(); rd_addr_q.delete();
          addr_hold_viol = 0; stab_viol = 0; both_viol = 0; drop_viol = 0;
          max_out = 0; ret_idx = 0; stall_cnt = 0;
        end
        if (write_req && read_req) both_viol++;
        if (hold_pending && ({write_req, burstbegin, size, be, wdata, address} !== hold_vec))
          stab_viol++;
        hold_pending = write_req && !ready;
        if (hold_pending) begin
          stall_cnt++;
          hold_vec = {write_req, burstbegin, size, be, wdata, address};
        end
        if (write_req && ready) begin
          if (burstbegin) begin
            wr_burst_addr = address; wr_k = 0; wr_bb_q.push_back(address);
          end else if (address !== wr_burst_addr) addr_hold_viol++;
          mem[address + 24'(wr_k)] = wdata;
          wr_data_q.push_back(wdata);
          wr_k++;
        end
        if (out_cnt >= MAXO && read_req) drop_viol++;
        if (read_req && ready) begin
          rd_addr_q.push_back(address);
          out_cnt++;
          for (int k = 0; k < BURST; k++) begin
            beat_t b;
            logic [23:0] a;
            a = address + 24'(k);
            b.due = cyc + rd_lat;
            if (b.due <= last_due) b.due = last_due + 1;
            last_due = b.due;
            b.data = mem.exists(a) ? mem[a] : 32'h0;
            pend.push_back(b);
          end
        end
        if (rdata_valid) begin
          ret_k++;
          if (ret_k == BURST) begin ret_k = 0; out_cnt--; end
        end
        if (out_cnt > max_out) max_out = out_cnt;
      end
      @(negedge clk);
      if (ready_toggle) ready = ~ready;
      else              ready = 1'b1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rdata = pend[0].data;
        if (ret_idx == corrupt_idx) rdata = rdata ^ 32'h1;
        rdata_valid = 1'b1;
        pend.pop_front();
        ret_idx++;
      end else begin
        rdata_valid = 1'b0;
        rdata = '0;
      end
    end
  end

  task automatic run_start(input logic [23:0] b, input logic [15:0] n, input logic [31:0] s);
    @(negedge clk);
    cfg_base = b; cfg_num = n; cfg_seed = s;
    arm_clear = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; arm_clear = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (done !== 1'b1 && i < budget) begin @(negedge clk); i++; end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++; $display("FAIL %s_done: got %b expected 1 after %0d cycles", name, done, budget);
    end
  endtask

  task automatic check_result(input string name, input logic exp_pass, input logic [15:0] exp_err);
    vectors++;
    if (pass !== exp_pass) begin miscompares++; $display("FAIL %s_pass: got %b expected %b", name, pass, exp_pass); end
    vectors++;
    if (err_count !== exp_err) begin miscompares++; $display("FAIL %s_err_count: got %0d expected %0d", name, err_count, exp_err); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy: got %b expected 0", name, busy); end
    vectors++;
    if (both_viol !== 0) begin miscompares++; $display("FAIL %s_wr_rd_overlap: got %0d expected 0", name, both_viol); end
  endtask

  task automatic check_writes(input string name, input int nbursts, input logic [23:0] base, input logic [31:0] seed);
    logic [31:0] gd;
    logic [23:0] ga;
    vectors++;
    if (wr_data_q.size() !== nbursts * BURST) begin
      miscompares++; $display("FAIL %s_wr_count: got %0d expected %0d", name, wr_data_q.size(), nbursts * BURST);
    end
    for (int i = 0; i < nbursts * BURST; i++) begin
      gd = (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxxxxxx;
      vectors++;
      if (gd !== seed + 32'(i)) begin miscompares++; $display("FAIL %s_wdata[%0d]: got %h expected %h", name, i, gd, seed + 32'(i)); end
    end
    for (int i = 0; i < nbursts; i++) begin
      ga = (i < wr_bb_q.size()) ? wr_bb_q[i] : 24'hxxxxxx;
      vectors++;
      if (ga !== base + 24'(BURST * i)) begin miscompares++; $display("FAIL %s_wr_addr[%0d]: got %h expected %h", name, i, ga, base + 24'(BURST * i)); end
      ga = (i < rd_addr_q.size()) ? rd_addr_q[i] : 24'hxxxxxx;
      vectors++;
      if (ga !== base + 24'(BURST * i)) begin miscompares++; $display("FAIL %s_rd_addr[%0d]: got %h expected %h", name, i, ga, base + 24'(BURST * i)); end
    end
    vectors++;
    if (addr_hold_viol !== 0) begin miscompares++; $display("FAIL %s_addr_hold: got %0d changes expected 0", name, addr_hold_viol); end
  endtask

  task automatic check_outputs_zero(input string name);
    vectors++;
    if ({busy, done, pass, write_req, read_req, burstbegin} !== 6'b0) begin
      miscompares++; $display("FAIL %s_flags: got %b expected 000000", name, {busy, done, pass, write_req, read_req, burstbegin});
    end
    vectors++;
    if (err_count !== 16'h0 || first_err_addr !== 24'h0) begin
      miscompares++; $display("FAIL %s_err: got %h/%h expected 0/0", name, err_count, first_err_addr);
    end
    vectors++;
    if ({size, be, wdata, address} !== 63'h0) begin
      miscompares++; $display("FAIL %s_local_bus: got %h expected 0", name, {size, be, wdata, address});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cfg_base = 24'h0; cfg_num = 16'd4; cfg_seed = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || write_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_early_start: got busy=%b wr=%b expected 0/0", busy, write_req);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    run_start(24'h0, 16'd4, 32'h100);
    wait_done("basic", 500);
    check_writes("basic", 4, 24'h0, 32'h100);
    check_result("basic", 1'b1, 16'd0);
  endtask

  task automatic test_ready_toggle();
    ready_toggle = 1'b1;
    run_start(24'h20, 16'd4, 32'h100);
    wait_done("toggle", 800);
    ready_toggle = 1'b0;
    check_writes("toggle", 4, 24'h20, 32'h100);
    check_result("toggle", 1'b1, 16'd0);
    vectors++;
    if (stab_viol !== 0) begin miscompares++; $display("FAIL toggle_stable: got %0d changes expected 0", stab_viol); end
    vectors++;
    if (stall_cnt == 0) begin miscompares++; $display("FAIL toggle_stalls: got %0d stalls expected >0", stall_cnt); end
  endtask

  task automatic test_corrupt();
    corrupt_idx = 5;
    run_start(24'h10, 16'd4, 32'h55);
    wait_done("corrupt", 500);
    corrupt_idx = -1;
    check_result("corrupt", 1'b0, 16'd1);
    vectors++;
    if (first_err_addr !== 24'h14) begin miscompares++; $display("FAIL corrupt_first_addr: got %h expected 000014", first_err_addr); end
  endtask

  task automatic test_outstanding();
    rd_lat = 40;
    run_start(24'h100, 16'd20, 32'hABCD0000);
    wait_done("outst", 3000);
    rd_lat = 3;
    check_writes("outst", 20, 24'h100, 32'hABCD0000);
    check_result("outst", 1'b1, 16'd0);
    vectors++;
    if (max_out !== MAXO) begin miscompares++; $display("FAIL outst_max: got %0d expected %0d", max_out, MAXO); end
    vectors++;
    if (drop_viol !== 0) begin miscompares++; $display("FAIL outst_req_at_max: got %0d expected 0", drop_viol); end
  endtask

  task automatic test_wrap();
    run_start(24'hFFFFFE, 16'd2, 32'h1234);
    wait_done("wrap", 500);
    vectors++;
    if (wr_bb_q.size() < 2 || wr_bb_q[1] !== 24'h000000) begin
      miscompares++; $display("FAIL wrap_addr: got %h expected 000000", (wr_bb_q.size() < 2) ? 24'hxxxxxx : wr_bb_q[1]);
    end
    check_writes("wrap", 2, 24'hFFFFFE, 32'h1234);
    check_result("wrap", 1'b1, 16'd0);
  endtask

  task automatic test_zero_bursts();
    run_start(24'h5, 16'd0, 32'h1);
    wait_done("zero", 10);
    check_result("zero", 1'b1, 16'd0);
    vectors++;
    if (wr_data_q.size() !== 0) begin miscompares++; $display("FAIL zero_writes: got %0d expected 0", wr_data_q.size()); end
  endtask

  task automatic test_init_pause();
    int n = 0;
    int i = 0;
    run_start(24'h40, 16'd8, 32'h7);
    while (wr_data_q.size() < 3 && i < 100) begin @(negedge clk); i++; end
    init_done = 1'b0;
    #1;
    vectors++;
    if (write_req !== 1'b0 || read_req !== 1'b0) begin
      miscompares++; $display("FAIL pause_req: got wr=%b rd=%b expected 0/0", write_req, read_req);
    end
    n = wr_data_q.size();
    repeat (5) @(negedge clk);
    vectors++;
    if (wr_data_q.size() !== n || busy !== 1'b1) begin
      miscompares++; $display("FAIL pause_frozen: got %0d writes busy=%b expected %0d/1", wr_data_q.size(), busy, n);
    end
    init_done = 1'b1;
    @(negedge clk);
    cfg_num = 16'd1; cfg_base = 24'h999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("pause", 500);
    check_writes("pause", 8, 24'h40, 32'h7);
    check_result("pause", 1'b1, 16'd0);
  endtask

  task automatic test_reset_drain();
    int i = 0;
    rd_lat = 40;
    run_start(24'h200, 16'd4, 32'h900);
    while (rd_addr_q.size() < 4 && i < 500) begin @(negedge clk); i++; end
    vectors++;
    if (rd_addr_q.size() !== 4) begin miscompares++; $display("FAIL drain_reach: got %0d reads expected 4", rd_addr_q.size()); end
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_outputs_zero("drain_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd_lat = 3;
    run_start(24'h300, 16'd3, 32'h42);
    wait_done("drain_rerun", 500);
    check_writes("drain_rerun", 3, 24'h300, 32'h42);
    check_result("drain_rerun", 1'b1, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; init_done = 1'b1;
    cfg_base = '0; cfg_num = '0; cfg_seed = '0;
    rd_lat = 3; corrupt_idx = -1; ready_toggle = 1'b0; arm_clear = 1'b0;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_corrupt();
    test_outstanding();
    test_wrap();
    test_zero_bursts();
    test_init_pause();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr2_local_traffic_master.md
DDR2_LOCAL_TRAFFIC_MASTER -- requirements
Module: ddr2_local_traffic_master

Interface
REQ-001 Parameter ADDR_W, default 24: local word-address width.
REQ-002 Parameter DATA_W, default 32: local data width.
REQ-003 Parameter BE_W, default 4: byte-enable width (DATA_W/8).
REQ-004 Parameter BURST, default 2: beats per request, driven on local_size, range 1..4.
REQ-005 Parameter MAX_OUTSTANDING, default 8: maximum read bursts accepted but not fully returned.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 phy_clk  in  1  sole clock, the controller's local-side clock.
REQ-008 reset_phy_clk_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  single-cycle run request.
REQ-010 cfg_base_addr  in  ADDR_W  first burst address.
REQ-011 cfg_num_bursts  in  16  number of bursts to write, then read back.
REQ-012 cfg_seed  in  DATA_W  data pattern seed.
REQ-013 busy  out  1  run in progress.
REQ-014 done  out  1  sticky run-complete flag.
REQ-015 pass  out  1  valid when done; 1 = no miscompare.
REQ-016 err_count  out  16  saturating miscompare count.
REQ-017 first_err_addr  out  ADDR_W  burst address of first miscompare.
REQ-018 local_init_done, local_ready  in  1 each  controller calibrated / command accept.
REQ-019 local_address  out  ADDR_W; local_write_req, local_read_req, local_burstbegin  out  1 each; local_size  out  3; local_be  out  BE_W; local_wdata  out  DATA_W.
REQ-020 local_rdata  in  DATA_W; local_rdata_valid  in  1  read return beat.

Function
REQ-021 The FSM SHALL have states IDLE, WR, RD_ISSUE, RD_DRAIN and DONE.
REQ-022 In IDLE or DONE, start with local_init_done=1 SHALL latch the cfg_* inputs, clear err_count, first_err_addr, done and pass, set busy, and enter WR. Start SHALL be ignored otherwise.
REQ-023 If cfg_num_bursts=0, start SHALL go directly to DONE with pass=1.
REQ-024 Burst address: base + burst_idx*BURST, modulo 2^ADDR_W (wraps silently).
REQ-025 WR: local_write_req=1, local_be all ones, local_size=BURST, local_wdata=seed+global_beat_idx (mod 2^DATA_W).
REQ-026 WR: local_burstbegin SHALL be 1 only on beat 0 of each burst, and local_address SHALL be held for all beats of that burst.
REQ-027 A write beat is accepted when local_write_req&&local_ready. Until acceptance, all local outputs SHALL hold stable.
REQ-028 On acceptance of the final beat of the final burst, the FSM SHALL enter RD_ISSUE on the next cycle, with zero idle cycles between write beats otherwise.
REQ-029 RD_ISSUE: local_read_req=1, local_burstbegin=1 and local_size=BURST SHALL be asserted only while outstanding<MAX_OUTSTANDING. A read is accepted on local_read_req&&local_ready.
REQ-030 After the final read is accepted, the FSM SHALL enter RD_DRAIN.
REQ-031 The outstanding counter SHALL increment on read accept and decrement on the BURST-th returned beat of a burst; on a simultaneous accept and decrement it SHALL be unchanged.
REQ-032 Each local_rdata_valid beat in RD_ISSUE/RD_DRAIN SHALL be compared with seed+rd_beat_idx.
REQ-033 On mismatch, err_count SHALL increment (saturating at 16'hFFFF). The first mismatch SHALL capture that burst's address into first_err_addr.
REQ-034 local_rdata_valid in IDLE, WR or DONE SHALL be ignored.
REQ-035 RD_DRAIN SHALL go to DONE one cycle after the final expected beat; DONE sets done=1, busy=0, pass=(err_count==0).
REQ-036 While local_init_done=0 mid-run, read/write requests SHALL be forced low with state and counters frozen; the run resumes when it returns to 1.
REQ-037 local_write_req and local_read_req SHALL never be asserted in the same cycle.

Reset
REQ-038 While reset_phy_clk_n=0: state IDLE; all outputs, counters and latched configuration 0.
REQ-039 Reset asserted mid-run SHALL abort immediately, with no further requests.
REQ-040 Reset deassertion is synchronised internally; the first start is honoured no earlier than 2 phy_clk cycles after deassertion.

Structure
REQ-041 Package ddr2_traffic_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-042 Sub-module ddr2_traffic_checker SHALL contain the read expected-data generator, the compare logic, err_count and first_err_addr.

Verification
REQ-043 base=0, bursts=4, seed=0x100, ready always 1, ideal memory model: 8 write beats with data 0x100..0x107 and addresses 0,2,4,6; done=1, pass=1.
REQ-044 local_ready toggling 1-0 every cycle during WR: outputs held stable while ready=0, no beat lost or duplicated.
REQ-045 Memory model corrupts beat 5: err_count=1, first_err_addr=base+4, pass=0.
REQ-046 Read latency 40 cycles, bursts=20: outstanding never exceeds 8, and local_read_req drops while it equals 8.
REQ-047 base=0xFFFFFE, bursts=2: the second burst address is 0x000000.
REQ-048 Reset pulse during RD_DRAIN: all outputs 0 next cycle; a subsequent start runs cleanly with pass=1.
